draw_board_marks: RTL
=====================

// Module: draw_board_marks
// PURPOSE
//  Parametrised overlay stage for the VGA pipeline. Replaces the nine fixed single-cell painters.
//  Paints every cell of the 3x3 board from a packed board state: X colour, O colour or unchanged.
//  Board state is snapshotted once per frame, so the picture never tears mid-frame.
//  Winning cells are highlighted, with optional blinking.
//  Sits between the background/grid stage and the mouse/cursor stage; timing signals pass through.
// PARAMETERS
//  BOARD_X0     0        left pixel of the board
//  BOARD_Y0     0        top line of the board
//  CELL_W       339      cell width in pixels
//  CELL_H       256      cell height in lines
//  BORDER       4        inset (px/lines) left unpainted on each cell edge
//  COLOR_X      12'hf00  fill colour for X cells
//  COLOR_O      12'h00f  fill colour for O cells
//  COLOR_WIN    12'hff0  fill colour for winning cells
//  BLINK_FRAMES 30       frames per blink phase (>=1); used only with DRAW_MARKS_BLINK_EN
// PORTS
//  pclk        in   1   pixel clock
//  rst         in   1   reset, asynchronous, active-high
//  hcount_in   in   11  horizontal pixel counter
//  hsync_in    in   1   hsync
//  hblnk_in    in   1   horizontal blank
//  vcount_in   in   11  vertical line counter
//  vsync_in    in   1   vsync
//  vblnk_in    in   1   vertical blank
//  rgb_in      in   12  upstream pixel colour
//  board_in    in   18  cell c state at [2c+1:2c]; 00 empty, 01 X, 10 O, 11 empty; c=row*3+col, 0=top-left
//  win_mask    in   9   bit c = cell c belongs to the winning line
//  hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out   out  11/1/1/11/1/1  delayed timing
//  rgb_out     out  12  output pixel colour
// BEHAVIOUR
//  - One clock, pclk; rst is asynchronous active-high.
//  - rst clears every register and output to 0, including timing outputs, snapshot and blink state.
//  - After reset, no marks are drawn until the first snapshot.
//  - Latency is exactly 2 pclk for all outputs; the timing signals are delayed in lockstep with rgb_out.
//    Stage 1 registers timing, cell index, cell hit, blank and the snapshot lookup.
//    Stage 2 registers the colour mux result.
//  - Snapshot: on the cycle where vblnk_in=1 and the registered vblnk_in=0 (rising edge), board_q<=board_in and win_q<=win_mask.
//    Changes to board_in/win_mask at any other time have no visible effect until the next edge.
//  - Hit: col c when BOARD_X0+c*CELL_W+BORDER <= hcount_in < BOARD_X0+(c+1)*CELL_W-BORDER.
//    Row r is defined the same way with BOARD_Y0, CELL_H and vcount_in. Hit requires both.
//    All comparisons are 12-bit unsigned, so no wrap. No dividers: use constant compares only.
//  - Colour priority, highest first:
//    hblnk|vblnk -> rgb_in;
//    no hit -> rgb_in;
//    cell empty (00/11) -> rgb_in;
//    win_q[c] -> COLOR_WIN (subject to blink);
//    X -> COLOR_X;
//    O -> COLOR_O.
//  - win_q[c] set on an empty cell is ignored; the cell passes rgb_in.
//  - Blink FSM (only with the macro), states SHOW, HIDE; reset state is SHOW with frame_cnt=0.
//    On each snapshot edge frame_cnt increments.
//    At BLINK_FRAMES-1, frame_cnt wraps to 0 and the state toggles (SHOW<->HIDE).
//    In HIDE, winning cells output rgb_in.
//    A change of win_mask does not restart the counter.
// CONFIGURATION
//  DRAW_MARKS_BLINK_EN defined:
//    blink FSM and a frame_cnt of $clog2(BLINK_FRAMES) bits (min 1) are built; winning cells alternate as above.
//  DRAW_MARKS_BLINK_EN undefined:
//    no FSM or counter; winning cells are always COLOR_WIN; BLINK_FRAMES is ignored.
// STRUCTURE
//  - board_pkg: CELL_EMPTY=2'b00, CELL_X=2'b01, CELL_O=2'b10, GRID_N=3, NUM_CELLS=9, cell_state_t (2-bit).
//  - Sub-module board_cell_locator: pure combinational (hcount, vcount) -> {hit, cell_idx[3:0]}.
//    Parametrised by BOARD_X0, BOARD_Y0, CELL_W, CELL_H, BORDER; its output is registered by stage 1 here.
// TESTING (defaults unless stated; t = cycle pixel applied)
//  1. Reset: assert rst mid-line -> all outputs 0 immediately, without waiting for a clock edge.
//     After release, rgb_in=12'h123 outside the board -> rgb_out=12'h123 at t+2.
//  2. Snapshot: board_in cell6=01, pixel (100,600) before any vblnk rise -> rgb_out=rgb_in.
//     After a vblnk rise, same pixel -> rgb_out=12'hf00 at t+2, hsync/vcount aligned.
//  3. Border: cell0=10; h=3,v=100 -> rgb_in; h=4 -> 12'h00f; h=334 -> 12'h00f; h=335 -> rgb_in.
//  4. Mid-frame update: change cell4 from 00 to 01 while vblnk=0 -> pixel (500,380) stays rgb_in.
//     After the next vblnk rise -> 12'hf00.
//  5. Blink (macro on, BLINK_FRAMES=2): cells 0,4,8=01, win_mask=9'b100010001.
//     Frames 1-2 -> 12'hff0; frames 3-4 -> rgb_in; frame 5 -> 12'hff0. Macro off -> 12'hff0 in every frame.
//  6. Codes/blank: cell2=11 -> rgb_in; a board pixel with hblnk_in=1 -> rgb_in.

Source files
------------

// File: rtl/board_pkg.sv
// Shared types and constants for the 3x3 board overlay (cell codes, grid size, blink states).
package board_pkg;

  localparam int GRID_N    = 3;
  localparam int NUM_CELLS = 9;

  typedef logic [1:0] cell_state_t;

  localparam cell_state_t CELL_EMPTY     = 2'b00;
  localparam cell_state_t CELL_X         = 2'b01;
  localparam cell_state_t CELL_O         = 2'b10;
  localparam cell_state_t CELL_EMPTY_ALT = 2'b11;

  typedef enum logic {
    BLINK_SHOW = 1'b0,
    BLINK_HIDE = 1'b1
  } blink_state_t;

  function automatic logic cell_is_empty(input cell_state_t s);
    return (s == CELL_EMPTY) || (s == CELL_EMPTY_ALT);
  endfunction

endpackage

// File: rtl/board_cell_locator.sv
// Combinational pixel-to-cell mapping: constant range compares only, the inset border counts as a miss.
module board_cell_locator
  import board_pkg::*;
#(
  parameter int BOARD_X0 = 0,
  parameter int BOARD_Y0 = 0,
  parameter int CELL_W   = 339,
  parameter int CELL_H   = 256,
  parameter int BORDER   = 4
) (
  input  logic [10:0] hcount_i,
  input  logic [10:0] vcount_i,
  output logic        hit_o,
  output logic [3:0]  cell_idx_o
);

  logic [11:0]       h_ext;
  logic [11:0]       v_ext;
  logic [GRID_N-1:0] col_hit;
  logic [GRID_N-1:0] row_hit;
  logic [1:0]        col_idx;
  logic [1:0]        row_idx;

  assign h_ext = {1'b0, hcount_i};
  assign v_ext = {1'b0, vcount_i};

  always_comb begin
    col_hit = '0;
    row_hit = '0;
    col_idx = 2'd0;
    row_idx = 2'd0;
    for (int c = 0; c < GRID_N; c++) begin
      col_hit[c] = (h_ext >= 12'(BOARD_X0 + c * CELL_W + BORDER)) &&
                   (h_ext <  12'(BOARD_X0 + (c + 1) * CELL_W - BORDER));
      row_hit[c] = (v_ext >= 12'(BOARD_Y0 + c * CELL_H + BORDER)) &&
                   (v_ext <  12'(BOARD_Y0 + (c + 1) * CELL_H - BORDER));
      if (col_hit[c]) col_idx = 2'(c);
      if (row_hit[c]) row_idx = 2'(c);
    end
  end

  assign hit_o      = (|col_hit) && (|row_hit);
  assign cell_idx_o = 4'(row_idx) * 4'(GRID_N) + 4'(col_idx);

endmodule

// File: rtl/draw_board_marks.sv
// Two-stage VGA overlay painting X/O/win colours from a once-per-frame board snapshot.
// Optional blinking of winning cells is built when DRAW_MARKS_BLINK_EN is defined.
module draw_board_marks
  import board_pkg::*;
#(
  parameter int          BOARD_X0     = 0,
  parameter int          BOARD_Y0     = 0,
  parameter int          CELL_W       = 339,
  parameter int          CELL_H       = 256,
  parameter int          BORDER       = 4,
  parameter logic [11:0] COLOR_X      = 12'hf00,
  parameter logic [11:0] COLOR_O      = 12'h00f,
  parameter logic [11:0] COLOR_WIN    = 12'hff0,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [17:0] board_in,
  input  logic [8:0]  win_mask,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  logic [17:0] board_q;
  logic [8:0]  win_q;
  logic        snap_edge;

  logic        loc_hit;
  logic [3:0]  loc_idx;
  cell_state_t cell_lookup;
  logic        win_lookup;

  logic [10:0] hcount_s1_q, vcount_s1_q;
  logic        hsync_s1_q, hblnk_s1_q, vsync_s1_q, vblnk_s1_q;
  logic [11:0] rgb_s1_q;
  logic        blank_s1_q, hit_s1_q, win_s1_q;
  logic [3:0]  idx_s1_q;
  cell_state_t state_s1_q;

  logic [10:0] hcount_q, vcount_q;
  logic        hsync_q, hblnk_q, vsync_q, vblnk_q;
  logic [11:0] rgb_q, rgb_d;
  logic        win_hide;

  // Snapshot on the rising edge of vblnk_in, detected against the stage-1 copy.
  assign snap_edge = vblnk_in & ~vblnk_s1_q;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      board_q <= '0;
      win_q   <= '0;
    end else if (snap_edge) begin
      board_q <= board_in;
      win_q   <= win_mask;
    end
  end

  board_cell_locator #(
    .BOARD_X0 (BOARD_X0),
    .BOARD_Y0 (BOARD_Y0),
    .CELL_W   (CELL_W),
    .CELL_H   (CELL_H),
    .BORDER   (BORDER)
  ) u_locator (
    .hcount_i   (hcount_in),
    .vcount_i   (vcount_in),
    .hit_o      (loc_hit),
    .cell_idx_o (loc_idx)
  );

  always_comb begin
    cell_lookup = CELL_EMPTY;
    win_lookup  = 1'b0;
    for (int c = 0; c < NUM_CELLS; c++) begin
      if (loc_idx == 4'(c)) begin
        cell_lookup = board_q[2*c +: 2];
        win_lookup  = win_q[c];
      end
    end
  end

`ifdef DRAW_MARKS_BLINK_EN
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  blink_state_t     blink_state_q, blink_state_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             hide_q;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      blink_state_q <= BLINK_SHOW;
      frame_cnt_q   <= '0;
      hide_q        <= 1'b0;
    end else begin
      blink_state_q <= blink_state_d;
      frame_cnt_q   <= frame_cnt_d;
      // The displayed phase is latched with the board, one frame behind the FSM.
      if (snap_edge) hide_q <= (blink_state_q == BLINK_HIDE);
    end
  end

  always_comb begin
    blink_state_d = blink_state_q;
    frame_cnt_d   = frame_cnt_q;
    if (snap_edge) begin
      if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_d   = '0;
        blink_state_d = (blink_state_q == BLINK_SHOW) ? BLINK_HIDE : BLINK_SHOW;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  assign win_hide = hide_q;
`else
  assign win_hide = 1'b0;
`endif

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hcount_s1_q <= '0;
      vcount_s1_q <= '0;
      hsync_s1_q  <= 1'b0;
      hblnk_s1_q  <= 1'b0;
      vsync_s1_q  <= 1'b0;
      vblnk_s1_q  <= 1'b0;
      rgb_s1_q    <= '0;
      blank_s1_q  <= 1'b0;
      hit_s1_q    <= 1'b0;
      idx_s1_q    <= '0;
      state_s1_q  <= CELL_EMPTY;
      win_s1_q    <= 1'b0;
    end else begin
      hcount_s1_q <= hcount_in;
      vcount_s1_q <= vcount_in;
      hsync_s1_q  <= hsync_in;
      hblnk_s1_q  <= hblnk_in;
      vsync_s1_q  <= vsync_in;
      vblnk_s1_q  <= vblnk_in;
      rgb_s1_q    <= rgb_in;
      blank_s1_q  <= hblnk_in | vblnk_in;
      hit_s1_q    <= loc_hit;
      idx_s1_q    <= loc_idx;
      state_s1_q  <= cell_lookup;
      win_s1_q    <= win_lookup;
    end
  end

  always_comb begin
    rgb_d = rgb_s1_q;
    if (!blank_s1_q && hit_s1_q && !cell_is_empty(state_s1_q)) begin
      if (win_s1_q)                  rgb_d = win_hide ? rgb_s1_q : COLOR_WIN;
      else if (state_s1_q == CELL_X) rgb_d = COLOR_X;
      else                           rgb_d = COLOR_O;
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hcount_q <= '0;
      vcount_q <= '0;
      hsync_q  <= 1'b0;
      hblnk_q  <= 1'b0;
      vsync_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      rgb_q    <= '0;
    end else begin
      hcount_q <= hcount_s1_q;
      vcount_q <= vcount_s1_q;
      hsync_q  <= hsync_s1_q;
      hblnk_q  <= hblnk_s1_q;
      vsync_q  <= vsync_s1_q;
      vblnk_q  <= vblnk_s1_q;
      rgb_q    <= rgb_d;
    end
  end

  assign hcount_out = hcount_q;
  assign vcount_out = vcount_q;
  assign hsync_out  = hsync_q;
  assign hblnk_out  = hblnk_q;
  assign vsync_out  = vsync_q;
  assign vblnk_out  = vblnk_q;
  assign rgb_out    = rgb_q;

endmodule
